// File: rtl/rc_tx_framer.sv
// TX framer for the redundancy link: streams a RAM payload, drives the CRC-16 engine
// and appends the returned FCS. Optional length header enabled by RC_TX_LEN_HDR_EN.
module rc_tx_framer #(
    parameter int ADDR_W  = 11,
    parameter int LEN_W   = 11,
    parameter int MAX_LEN = 1024
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic              tx_start,
    input  logic [ADDR_W-1:0] tx_base,
    input  logic [LEN_W-1:0]  tx_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              crc_sop,
    output logic [7:0]        crc_din,
    output logic              crc_din_vld,
    output logic              crc_cap,
    input  logic [15:0]       crc_dout,
    output logic [7:0]        tx_dout,
    output logic              tx_vld,
    input  logic              tx_rdy,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef RC_TX_LEN_HDR_EN
        S_HDR,
`endif
        S_PAYLOAD,
        S_CRC_WAIT,
        S_CRC_HI,
        S_CRC_LO
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rd_idx;
    logic [LEN_W-1:0]  r_rd_left;
    logic [LEN_W-1:0]  r_tx_left;
    logic [7:0]        r_fifo [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_cnt;
    logic              r_pend;
    logic [15:0]       r_fcs;
    logic              r_sop;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
`ifdef RC_TX_LEN_HDR_EN
    logic              r_hdr_idx;
`endif

    logic              w_vld;
    logic [7:0]        w_dout;
    logic              w_sof;
    logic              w_eof;
    logic              w_xfer;
    logic              w_pop;
    logic              w_last;
    logic              w_rd_phase;
    logic [2:0]        w_fill;
    logic              w_rd_en;
    logic              w_len_bad;

    assign w_xfer  = w_vld & tx_rdy;
    assign w_pop   = (r_state == S_PAYLOAD) & w_xfer;
    assign w_last  = (r_tx_left == LEN_W'(1));

`ifdef RC_TX_LEN_HDR_EN
    assign w_rd_phase = (r_state == S_PAYLOAD) | (r_state == S_HDR);
`else
    assign w_rd_phase = (r_state == S_PAYLOAD);
`endif

    // Occupancy is taken after this cycle's pop so a steady 1 byte/cycle stream
    // keeps one byte buffered and one read in flight.
    assign w_fill  = 3'(r_cnt) - 3'(w_pop) + 3'(r_pend);
    assign w_rd_en = w_rd_phase & (r_rd_left != '0) & (w_fill < 3'd2);

    assign w_len_bad = (tx_len == '0) | (32'(tx_len) > 32'(MAX_LEN));

    always_comb begin
        w_vld  = 1'b0;
        w_dout = '0;
        w_sof  = 1'b0;
        w_eof  = 1'b0;
        case (r_state)
`ifdef RC_TX_LEN_HDR_EN
            // First HDR cycle coincides with crc_sop, so the header waits one cycle.
            S_HDR: begin
                w_vld  = ~r_sop;
                w_dout = r_hdr_idx ? r_len[7:0] : 8'(r_len >> 8);
                w_sof  = ~r_sop & ~r_hdr_idx;
            end
`endif
            S_PAYLOAD: begin
                w_vld  = (r_cnt != 2'd0);
                w_dout = w_vld ? r_fifo[r_rptr] : '0;
`ifndef RC_TX_LEN_HDR_EN
                w_sof  = w_vld & (r_tx_left == r_len);
`endif
            end
            S_CRC_HI: begin
                w_vld  = 1'b1;
                w_dout = r_fcs[15:8];
            end
            S_CRC_LO: begin
                w_vld  = 1'b1;
                w_dout = r_fcs[7:0];
                w_eof  = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_vld      = w_vld;
    assign tx_dout     = w_dout;
    assign tx_sof      = w_sof;
    assign tx_eof      = w_eof;
    assign rd_en       = w_rd_en;
    assign rd_addr     = r_base + ADDR_W'(r_rd_idx);
    assign crc_din     = w_dout;
    assign crc_din_vld = w_xfer & w_rd_phase;
    assign crc_cap     = w_pop & w_last;
    assign crc_sop     = r_sop;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_err      = r_err;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_rd_idx  <= '0;
            r_rd_left <= '0;
            r_tx_left <= '0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= '0;
            r_pend    <= 1'b0;
            r_fcs     <= '0;
            r_sop     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef RC_TX_LEN_HDR_EN
            r_hdr_idx <= 1'b0;
`endif
        end else begin
            r_sop  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_pend <= w_rd_en;

            if (w_rd_en) begin
                r_rd_idx  <= r_rd_idx + LEN_W'(1);
                r_rd_left <= r_rd_left - LEN_W'(1);
            end
            if (r_pend) begin
                r_fifo[r_wptr] <= rd_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + 2'(r_pend) - 2'(w_pop);

            case (r_state)
                S_IDLE: begin
                    // The tx_done cycle is still IDLE but does not accept a new start.
                    if (tx_start && !r_done) begin
                        if (w_len_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_base    <= tx_base;
                            r_len     <= tx_len;
                            r_rd_idx  <= '0;
                            r_rd_left <= tx_len;
                            r_tx_left <= tx_len;
                            r_sop     <= 1'b1;
                            r_busy    <= 1'b1;
`ifdef RC_TX_LEN_HDR_EN
                            r_hdr_idx <= 1'b0;
                            r_state   <= S_HDR;
`else
                            r_state   <= S_PAYLOAD;
`endif
                        end
                    end
                end
`ifdef RC_TX_LEN_HDR_EN
                S_HDR: begin
                    if (w_xfer) begin
                        if (r_hdr_idx) begin
                            r_state <= S_PAYLOAD;
                        end
                        r_hdr_idx <= 1'b1;
                    end
                end
`endif
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_tx_left <= r_tx_left - LEN_W'(1);
                        if (w_last) begin
                            r_state <= S_CRC_WAIT;
                        end
                    end
                end
                S_CRC_WAIT: begin
                    r_fcs   <= crc_dout;
                    r_state <= S_CRC_HI;
                end
                S_CRC_HI: begin
                    if (w_xfer) begin
                        r_state <= S_CRC_LO;
                    end
                end
                S_CRC_LO: begin
                    if (w_xfer) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_tx_framer.sv
// Directed self-checking bench for rc_tx_framer (default build, no length header).
module tb_rc_tx_framer;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        tx_start;
    logic [10:0] tx_base;
    logic [10:0] tx_len;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        crc_sop;
    logic [7:0]  crc_din;
    logic        crc_din_vld;
    logic        crc_cap;
    logic [15:0] crc_dout;
    logic [7:0]  tx_dout;
    logic        tx_vld;
    logic        tx_rdy;
    logic        tx_sof;
    logic        tx_eof;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_err;

    logic        rdy_mode = 1'b0;
    logic        rdy_ph   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    rc_tx_framer #(.ADDR_W(11), .LEN_W(11), .MAX_LEN(1024)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .tx_start(tx_start),
        .tx_base(tx_base), .tx_len(tx_len), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .crc_sop(crc_sop), .crc_din(crc_din),
        .crc_din_vld(crc_din_vld), .crc_cap(crc_cap), .crc_dout(crc_dout),
        .tx_dout(tx_dout), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_sof(tx_sof),
        .tx_eof(tx_eof), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) rdy_ph <= ~rdy_ph;
    assign tx_rdy = rdy_mode ? rdy_ph : 1'b1;

    // RAM model: one-cycle read latency
    logic [7:0] mem [0:2047];
    always @(posedge clk_sys) if (rd_en) rd_data <= mem[rd_addr];

    // CRC engine model: reflected CRC-16 (0xA001), init FFFF, inverted, byte-swapped out
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_fin(input logic [15:0] c);
        logic [15:0] v;
        v = ~c;
        return {v[7:0], v[15:8]};
    endfunction

    logic [15:0] eng_crc = 16'hFFFF;
    always @(posedge clk_sys) begin
        logic [15:0] base_c;
        logic [15:0] nxt;
        base_c = crc_sop ? 16'hFFFF : eng_crc;
        nxt    = crc_din_vld ? crc_upd(base_c, crc_din) : base_c;
        eng_crc <= nxt;
        if (crc_cap) crc_dout <= crc_fin(nxt);
    end

    // Monitor: samples on the falling edge what the next rising edge will transfer
    logic [7:0]  xd [0:511];
    logic        xs [0:511];
    logic        xe [0:511];
    logic        xc [0:511];
    int          xt [0:511];
    logic [10:0] ra [0:511];
    int cyc = 0, n_x = 0, n_ra = 0;
    int n_sop = 0, n_vld = 0, n_cap = 0, n_err = 0, n_done = 0, n_busy = 0, n_eof = 0;
    int done_cyc = 0, n_hold_viol = 0;
    logic       p_hold = 1'b0;
    logic [7:0] p_d;
    logic       p_s, p_e;

    always @(negedge clk_sys) begin
        cyc++;
        if (p_hold && !(tx_vld && tx_dout == p_d && tx_sof == p_s && tx_eof == p_e))
            n_hold_viol++;
        p_hold = tx_vld && !tx_rdy;
        p_d = tx_dout; p_s = tx_sof; p_e = tx_eof;
        if (tx_vld && tx_rdy) begin
            xd[n_x] = tx_dout; xs[n_x] = tx_sof; xe[n_x] = tx_eof;
            xc[n_x] = crc_cap; xt[n_x] = cyc;
            n_x++;
            if (tx_eof) n_eof++;
        end
        if (rd_en) begin ra[n_ra] = rd_addr; n_ra++; end
        if (crc_sop) n_sop++;
        if (crc_din_vld) n_vld++;
        if (crc_cap) n_cap++;
        if (tx_err) n_err++;
        if (tx_busy) n_busy++;
        if (tx_done) begin n_done++; done_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [10:0] b, input logic [10:0] l);
        @(posedge clk_sys); #1;
        tx_base = b; tx_len = l; tx_start = 1'b1;
        @(posedge clk_sys); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) @(negedge clk_sys);
        chk({tag, "_done_seen"}, 32'(n_done - d0), 32'd1);
    endtask

    task automatic verify_frame(input string tag, input int x0, input logic [10:0] b, input int len);
        logic [15:0] c, fcs;
        logic [10:0] a;
        c = 16'hFFFF;
        chk({tag, "_nbytes"}, 32'(n_x - x0), 32'(len + 2));
        for (int i = 0; i < len; i++) begin
            a = b + 11'(i);
            c = crc_upd(c, mem[a]);
            chk($sformatf("%s_byte%0d", tag, i), 32'(xd[x0 + i]), 32'(mem[a]));
            chk($sformatf("%s_sof%0d", tag, i), 32'(xs[x0 + i]), 32'(i == 0));
            chk($sformatf("%s_cap%0d", tag, i), 32'(xc[x0 + i]), 32'(i == len - 1));
        end
        fcs = crc_fin(c);
        chk({tag, "_fcs_hi"}, 32'(xd[x0 + len]), 32'(fcs[15:8]));
        chk({tag, "_fcs_lo"}, 32'(xd[x0 + len + 1]), 32'(fcs[7:0]));
        chk({tag, "_eof_hi"}, 32'(xe[x0 + len]), 32'd0);
        chk({tag, "_eof_lo"}, 32'(xe[x0 + len + 1]), 32'd1);
        chk({tag, "_done_lat"}, 32'(done_cyc - xt[x0 + len + 1]), 32'd1);
    endtask

    initial begin
        int x0, s0, v0, c0, e0, b0, r0, d0, h0, eo0;

        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 9; i++) mem[11'h100 + i] = 8'h31 + 8'(i);
        mem[11'h200] = 8'h00;
        mem[11'h7FE] = 8'hA1; mem[11'h7FF] = 8'hB2; mem[11'h000] = 8'hC3; mem[11'h001] = 8'hD4;

        rst_sys_n = 1'b0; tx_start = 1'b0; tx_base = '0; tx_len = '0;
        repeat (3) @(negedge clk_sys);
        chk("reset_outputs", 32'({rd_en, rd_addr, crc_sop, crc_din, crc_din_vld, crc_cap, tx_dout,
            tx_vld, tx_sof, tx_eof, tx_busy, tx_done, tx_err}), 32'd0);
        @(posedge clk_sys); #1 rst_sys_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // 9-byte "123456789", ready held high
        x0 = n_x; s0 = n_sop; v0 = n_vld; c0 = n_cap; r0 = n_ra;
        start_frame(11'h100, 11'd9);
        wait_done("t1", 200);
        verify_frame("t1", x0, 11'h100, 9);
        chk("t1_fcs_C8", 32'(xd[x0 + 9]), 32'hC8);
        chk("t1_fcs_B4", 32'(xd[x0 + 10]), 32'hB4);
        chk("t1_payload_back2back", 32'(xt[x0 + 8] - xt[x0]), 32'd8);
        chk("t1_fcs_gap", 32'(xt[x0 + 10] - xt[x0 + 8]), 32'd3);
        chk("t1_sop_cnt", 32'(n_sop - s0), 32'd1);
        chk("t1_vld_cnt", 32'(n_vld - v0), 32'd9);
        chk("t1_cap_cnt", 32'(n_cap - c0), 32'd1);
        chk("t1_rd_cnt", 32'(n_ra - r0), 32'd9);

        // Rejected lengths
        for (int k = 0; k < 2; k++) begin
            e0 = n_err; r0 = n_ra; b0 = n_busy; s0 = n_sop;
            start_frame(11'h100, (k == 0) ? 11'd0 : 11'd1025);
            repeat (4) @(negedge clk_sys);
            chk($sformatf("t2_%0d_err", k), 32'(n_err - e0), 32'd1);
            chk($sformatf("t2_%0d_rd", k), 32'(n_ra - r0), 32'd0);
            chk($sformatf("t2_%0d_busy", k), 32'(n_busy - b0), 32'd0);
            chk($sformatf("t2_%0d_sop", k), 32'(n_sop - s0), 32'd0);
        end

        // Same frame with ready toggling; a mid-frame bad start must be ignored
        rdy_mode = 1'b1;
        x0 = n_x; s0 = n_sop; v0 = n_vld; e0 = n_err; h0 = n_hold_viol;
        start_frame(11'h100, 11'd9);
        repeat (3) @(negedge clk_sys);
        start_frame(11'h100, 11'd0);
        wait_done("t3", 300);
        verify_frame("t3", x0, 11'h100, 9);
        chk("t3_fcs_C8", 32'(xd[x0 + 9]), 32'hC8);
        chk("t3_fcs_B4", 32'(xd[x0 + 10]), 32'hB4);
        chk("t3_vld_cnt", 32'(n_vld - v0), 32'd9);
        chk("t3_sop_cnt", 32'(n_sop - s0), 32'd1);
        chk("t3_no_err", 32'(n_err - e0), 32'd0);
        chk("t3_hold_stable", 32'(n_hold_viol - h0), 32'd0);
        rdy_mode = 1'b0;

        // Single-byte payload
        x0 = n_x;
        start_frame(11'h200, 11'd1);
        wait_done("t4", 100);
        verify_frame("t4", x0, 11'h200, 1);

        // Address wrap
        x0 = n_x; r0 = n_ra;
        start_frame(11'h7FE, 11'd4);
        wait_done("t5", 100);
        verify_frame("t5", x0, 11'h7FE, 4);
        chk("t5_rd_cnt", 32'(n_ra - r0), 32'd4);
        chk("t5_addr0", 32'(ra[r0]), 32'h7FE);
        chk("t5_addr1", 32'(ra[r0 + 1]), 32'h7FF);
        chk("t5_addr2", 32'(ra[r0 + 2]), 32'h000);
        chk("t5_addr3", 32'(ra[r0 + 3]), 32'h001);

        // Reset after 3 payload bytes, then a clean frame
        x0 = n_x; d0 = n_done; eo0 = n_eof;
        start_frame(11'h100, 11'd9);
        for (int i = 0; i < 50 && (n_x - x0) < 3; i++) @(negedge clk_sys);
        chk("t6_partial_seen", 32'(n_x - x0 >= 3), 32'd1);
        @(posedge clk_sys); #1 rst_sys_n = 1'b0;
        #1;
        chk("t6_reset_outputs", 32'({rd_en, rd_addr, crc_sop, crc_din, crc_din_vld, crc_cap, tx_dout,
            tx_vld, tx_sof, tx_eof, tx_busy, tx_done, tx_err}), 32'd0);
        @(posedge clk_sys); #1 rst_sys_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        chk("t6_no_eof", 32'(n_eof - eo0), 32'd0);
        x0 = n_x; s0 = n_sop;
        start_frame(11'h100, 11'd9);
        wait_done("t6", 200);
        verify_frame("t6", x0, 11'h100, 9);
        chk("t6_fcs_C8", 32'(xd[x0 + 9]), 32'hC8);
        chk("t6_fcs_B4", 32'(xd[x0 + 10]), 32'hB4);
        chk("t6_sop_cnt", 32'(n_sop - s0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
